// File: rtl/gsim_sweep_ctrl.sv
// rtl/gsim_sweep_ctrl.sv - Gauss-Seidel sweep sequencer: row issue, convergence test, result drain
module gsim_sweep_ctrl #(
    parameter int N        = 16,
    parameter int MIN_ITER = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  max_iter,
    input  logic [31:0] tol,
    output logic        row_req,
    output logic [3:0]  row_idx,
    input  logic        row_gnt,
    input  logic        row_done,
    input  logic [31:0] delta,
    output logic        out_req,
    output logic [3:0]  out_idx,
    input  logic        out_rdy,
    output logic        busy,
    output logic        done,
    output logic        converged,
    output logic [6:0]  iter_cnt
);

    localparam logic [3:0] LAST_ROW  = 4'(N - 1);
    localparam logic [6:0] MIN_SWEEP = 7'(MIN_ITER);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SWEEP_END,
        ST_DRAIN,
        ST_FIN
    } state_t;

    state_t      state, state_n;
    logic [3:0]  row_idx_n, out_idx_n;
    logic [6:0]  iter_cnt_n, iter_inc;
    logic        converged_n;
    logic [31:0] max_delta, max_delta_n;
    logic [6:0]  iter_lim, iter_lim_n;
    logic [31:0] tol_q, tol_n;
    logic [31:0] abs_delta;
    logic        row_req_n, out_req_n, busy_n, done_n;

    // Two's complement magnitude; the most negative value has no positive twin, so clamp it.
    always_comb begin
        abs_delta = delta;
        if (delta[31]) begin
            if (delta == 32'h8000_0000) begin
                abs_delta = 32'h7FFF_FFFF;
            end else begin
                abs_delta = ~delta + 32'd1;
            end
        end
    end

    assign iter_inc = iter_cnt + 7'd1;

    always_comb begin
        state_n     = state;
        row_idx_n   = row_idx;
        out_idx_n   = out_idx;
        iter_cnt_n  = iter_cnt;
        converged_n = converged;
        max_delta_n = max_delta;
        iter_lim_n  = iter_lim;
        tol_n       = tol_q;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n     = ST_ISSUE;
                    iter_lim_n  = (max_iter == 7'd0) ? 7'd1 : max_iter;
                    tol_n       = tol;
                    iter_cnt_n  = 7'd0;
                    converged_n = 1'b0;
                    max_delta_n = 32'd0;
                    row_idx_n   = 4'd0;
                    out_idx_n   = 4'd0;
                end
            end
            ST_ISSUE: begin
                if (row_gnt) begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (row_done) begin
                    if (abs_delta > max_delta) begin
                        max_delta_n = abs_delta;
                    end
                    if (row_idx == LAST_ROW) begin
                        state_n = ST_SWEEP_END;
                    end else begin
                        row_idx_n = row_idx + 4'd1;
                        state_n   = ST_ISSUE;
                    end
                end
            end
            ST_SWEEP_END: begin
                iter_cnt_n = iter_inc;
                // Tolerance is tested first so a solve that converges on its last allowed sweep reports it.
                if (iter_inc >= MIN_SWEEP && max_delta <= tol_q) begin
                    converged_n = 1'b1;
                    out_idx_n   = 4'd0;
                    state_n     = ST_DRAIN;
                end else if (iter_inc >= iter_lim) begin
                    out_idx_n = 4'd0;
                    state_n   = ST_DRAIN;
                end else begin
                    max_delta_n = 32'd0;
                    row_idx_n   = 4'd0;
                    state_n     = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (out_rdy) begin
                    if (out_idx == LAST_ROW) begin
                        state_n = ST_FIN;
                    end else begin
                        out_idx_n = out_idx + 4'd1;
                    end
                end
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they leave the register with the state itself.
        row_req_n = (state_n == ST_ISSUE);
        out_req_n = (state_n == ST_DRAIN);
        busy_n    = (state_n != ST_IDLE);
        done_n    = (state_n == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            row_idx   <= 4'd0;
            out_idx   <= 4'd0;
            iter_cnt  <= 7'd0;
            converged <= 1'b0;
            max_delta <= 32'd0;
            iter_lim  <= 7'd1;
            tol_q     <= 32'd0;
            row_req   <= 1'b0;
            out_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            row_idx   <= row_idx_n;
            out_idx   <= out_idx_n;
            iter_cnt  <= iter_cnt_n;
            converged <= converged_n;
            max_delta <= max_delta_n;
            iter_lim  <= iter_lim_n;
            tol_q     <= tol_n;
            row_req   <= row_req_n;
            out_req   <= out_req_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_gsim_sweep_ctrl.sv
// tb/tb_gsim_sweep_ctrl.sv - randomized bench for gsim_sweep_ctrl against a per-solve behavioural model
module tb_gsim_sweep_ctrl;

    localparam int N        = 16;
    localparam int MIN_ITER = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  max_iter = '0;
    logic [31:0] tol = '0;
    logic        row_req;
    logic [3:0]  row_idx;
    logic        row_gnt = 1'b0;
    logic        row_done = 1'b0;
    logic [31:0] delta = '0;
    logic        out_req;
    logic [3:0]  out_idx;
    logic        out_rdy = 1'b0;
    logic        busy, done, converged;
    logic [6:0]  iter_cnt;

    always #5 clk = ~clk;

    gsim_sweep_ctrl #(.N(N), .MIN_ITER(MIN_ITER)) dut (
        .clk(clk), .reset(reset), .start(start), .max_iter(max_iter), .tol(tol),
        .row_req(row_req), .row_idx(row_idx), .row_gnt(row_gnt), .row_done(row_done),
        .delta(delta), .out_req(out_req), .out_idx(out_idx), .out_rdy(out_rdy),
        .busy(busy), .done(done), .converged(converged), .iter_cnt(iter_cnt)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] plan [0:127][0:N-1];
    bit imm, stall4, toggle_rdy, stray, aborted;
    int abort_sw = -1;
    int abort_row = -1;
    int obs_row_hs, obs_out_hs, obs_iter;
    bit obs_conv, obs_done;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Sweep count and outcome derived directly from the delta plan.
    function automatic void model(input int mi, input logic [31:0] tv, output int sweeps, output bit conv);
        int eff;
        longint t;
        eff = (mi == 0) ? 1 : mi;
        t = longint'(tv);
        sweeps = 0;
        conv = 0;
        for (int s = 1; s <= 127; s++) begin
            longint m = 0;
            for (int r = 0; r < N; r++) begin
                longint v = longint'($signed(plan[s-1][r]));
                if (v < 0) v = -v;
                if (v > 64'h7FFF_FFFF) v = 64'h7FFF_FFFF;
                if (v > m) m = v;
            end
            if (s >= MIN_ITER && m <= t) begin
                sweeps = s;
                conv = 1;
                return;
            end
            if (s >= eff) begin
                sweeps = s;
                return;
            end
        end
    endfunction

    task automatic fill_const(input logic [31:0] v);
        for (int s = 0; s < 128; s++)
            for (int r = 0; r < N; r++) plan[s][r] = v;
    endtask

    task automatic fill_random();
        for (int s = 0; s < 128; s++)
            for (int r = 0; r < N; r++) begin
                int mag = $urandom_range(0, 2000 >> (s < 10 ? s : 10));
                plan[s][r] = $urandom_range(0, 1) ? -32'(mag) : 32'(mag);
                if ($urandom_range(0, 200) == 0) plan[s][r] = 32'h8000_0000;
            end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_row_req"}, row_req, 0);
        check({tag, "_out_req"}, out_req, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_converged"}, converged, 0);
        check({tag, "_iter_cnt"}, iter_cnt, 0);
        check({tag, "_row_idx"}, row_idx, 0);
        check({tag, "_out_idx"}, out_idx, 0);
    endtask

    // Called at a negedge with the DUT idle; drives a whole solve and checks it every cycle.
    task automatic run_solve(input logic [6:0] mi, input logic [31:0] tv);
        int exp_sweeps, sw, row, outn, dcnt, stall, cyc;
        bit exp_conv, waiting, just_granted, rdy_ph, fin, first, give, rdy;
        model(int'(mi), tv, exp_sweeps, exp_conv);
        sw = 0; row = 0; outn = 0; dcnt = 0; stall = 0; cyc = 0;
        waiting = 0; just_granted = 0; rdy_ph = 1; fin = 0; first = 1;
        obs_row_hs = 0; obs_out_hs = 0; obs_done = 0; obs_iter = 0; obs_conv = 0; aborted = 0;
        start = 1; max_iter = mi; tol = tv;
        @(negedge clk);
        max_iter = 7'($urandom);
        tol = $urandom;
        while (!fin && !aborted && cyc < 20000) begin
            cyc++;
            row_done = 0; row_gnt = 0; out_rdy = 0;
            start = stray && ($urandom_range(0, 2) == 0);
            if (first) begin
                check("first_row_req", row_req, 1);
                first = 0;
            end
            if (done) begin
                start = 0;
                check("done_sweeps", sw, exp_sweeps);
                check("done_iter", iter_cnt, exp_sweeps);
                check("done_conv", converged, exp_conv);
                check("done_outs", outn, N);
                obs_done = 1; obs_iter = iter_cnt; obs_conv = converged;
                @(negedge clk);
                check("done_once", done, 0);
                check("idle_busy", busy, 0);
                check("hold_iter", iter_cnt, exp_sweeps);
                check("hold_conv", converged, exp_conv);
                fin = 1;
            end else begin
                check("busy", busy, 1);
                if (waiting) begin
                    if (just_granted) check("row_req_drop", row_req, 0);
                    just_granted = 0;
                    if (sw == abort_sw && row == abort_row) begin
                        reset = 1; start = 0; aborted = 1;
                    end else if (dcnt == 0) begin
                        row_done = 1;
                        delta = plan[sw][row];
                        waiting = 0;
                        row++;
                        if (row == N) begin row = 0; sw++; end
                    end else begin
                        dcnt--;
                    end
                    if (!imm && !aborted) row_gnt = ($urandom_range(0, 5) == 0);
                end else if (row_req) begin
                    check("row_idx", row_idx, row);
                    check("row_iter_cnt", iter_cnt, sw);
                    check("row_conv_low", converged, 0);
                    check("row_in_budget", sw < exp_sweeps, 1);
                    give = imm ? 1'b1 : ($urandom_range(0, 2) != 0);
                    if (stall4 && row == 4 && stall < 5) begin give = 0; stall++; end
                    if (give) begin
                        row_gnt = 1; waiting = 1; just_granted = 1;
                        dcnt = imm ? 0 : $urandom_range(0, 3);
                        obs_row_hs++;
                    end else if (!imm && $urandom_range(0, 3) == 0) begin
                        row_done = 1;
                        delta = 32'h7FFF_FFFF;
                    end
                end
                if (out_req) begin
                    check("out_idx", out_idx, outn);
                    check("out_after_sweeps", sw, exp_sweeps);
                    check("out_conv", converged, exp_conv);
                    rdy = imm ? 1'b1 : (toggle_rdy ? rdy_ph : 1'($urandom_range(0, 1)));
                    rdy_ph = !rdy_ph;
                    out_rdy = rdy;
                    if (rdy) begin outn++; obs_out_hs++; end
                end else if (!imm && !aborted) begin
                    out_rdy = ($urandom_range(0, 3) == 0);
                end
                if (!aborted) @(negedge clk);
            end
        end
        check("solve_ended", fin | aborted, 1);
        start = 0; row_gnt = 0; row_done = 0; out_rdy = 0;
    endtask

    initial begin
        imm = 1; stall4 = 0; toggle_rdy = 0; stray = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 0;
        @(negedge clk);
        check_reset_vals("post_reset");

        // Fixed iteration budget, never converges.
        fill_const(32'd5);
        run_solve(7'd3, 32'd0);
        check("r034_row_hs", obs_row_hs, 48);
        check("r034_outs", obs_out_hs, 16);
        check("r034_iter", obs_iter, 3);
        check("r034_conv", obs_conv, 0);
        check("r034_done", obs_done, 1);

        // Converges on sweep 2.
        fill_const(32'd4);
        for (int r = 0; r < N; r++) plan[0][r] = 32'd100;
        run_solve(7'd75, 32'd10);
        check("r035_iter", obs_iter, 2);
        check("r035_conv", obs_conv, 1);
        check("r035_outs", obs_out_hs, 16);

        // Most negative delta saturates above a tolerance one below full scale.
        fill_const(32'd0);
        plan[1][7] = 32'h8000_0000;
        run_solve(7'd5, 32'h7FFF_FFFE);
        check("r036_iter", obs_iter, 3);
        check("r036_conv", obs_conv, 1);

        // Row-grant stall and toggling ready.
        imm = 0; stall4 = 1; toggle_rdy = 1;
        fill_random();
        run_solve(7'd2, 32'd0);
        check("r037_outs", obs_out_hs, 16);
        stall4 = 0; toggle_rdy = 0;

        // Reset in WAIT, row 9 of sweep 2, then a clean solve.
        imm = 1; abort_sw = 1; abort_row = 9;
        fill_const(32'd5);
        run_solve(7'd4, 32'd0);
        check("r038_aborted", aborted, 1);
        abort_sw = -1; abort_row = -1;
        @(negedge clk);
        check_reset_vals("r038");
        reset = 0;
        run_solve(7'd1, 32'd0);
        check("r038_iter", obs_iter, 1);
        check("r038_row_hs", obs_row_hs, 16);

        // Zero budget means one sweep; restarts while busy are ignored.
        imm = 0; stray = 1;
        fill_random();
        run_solve(7'd0, 32'hFFFF_FFFF);
        check("r039_iter", obs_iter, 1);
        check("r039_conv", obs_conv, 0);
        stray = 0;

        // Largest budget.
        imm = 1;
        fill_const(32'd5);
        run_solve(7'd127, 32'd0);
        check("r031_iter", obs_iter, 127);

        for (int k = 0; k < 10; k++) begin
            imm = $urandom_range(0, 1);
            toggle_rdy = $urandom_range(0, 1);
            stray = $urandom_range(0, 1);
            fill_random();
            run_solve(7'($urandom_range(0, 8)),
                      ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 300)));
            check("rand_done", obs_done, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
